wb_serial_master: RTL



---
 rtl/wb_serial_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone bridge: decodes 'W'/'R' commands from a UART byte
// stream, runs one 32-bit Wishbone cycle and returns the reply bytes.
module wb_serial_master #(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    localparam int unsigned TMO_W    = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);
    localparam logic [7:0]  CMD_WR   = 8'h57;
    localparam logic [7:0]  CMD_RD   = 8'h52;
    localparam logic [7:0]  RSP_OK   = 8'h2E;
    localparam logic [7:0]  RSP_ERR  = 8'h21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t             r_state, w_state;
    logic               r_op_we, w_op_we;
    logic [1:0]         r_cnt, w_cnt;
    logic [TMO_W-1:0]   r_tmo, w_tmo;
    logic [31:0]        r_adr, w_adr;
    logic [31:0]        r_dat, w_dat;
    logic [23:0]        r_rdata, w_rdata;
    logic               r_err, w_err;
    logic [7:0]         r_tx_data, w_tx_data;
    logic               r_tx_valid, w_tx_valid;
    logic               r_cyc, w_cyc;
    logic               r_we, w_we;
    logic [3:0]         r_sel, w_sel;
    logic               r_busy, w_busy;

    // Next-state and next-output logic; bus/busy outputs follow the next state
    always_comb begin
        w_state    = r_state;
        w_op_we    = r_op_we;
        w_cnt      = r_cnt;
        w_tmo      = r_tmo;
        w_adr      = r_adr;
        w_dat      = r_dat;
        w_rdata    = r_rdata;
        w_err      = r_err;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;

        unique case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    w_state = S_ADDR;
                    w_op_we = (rx_data == CMD_WR);
                    w_cnt   = 2'd0;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    w_adr = {r_adr[23:0], rx_data};
                    w_cnt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state = r_op_we ? S_DATA : S_BUS;
                        w_cnt   = 2'd0;
                        w_tmo   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    w_dat = {r_dat[23:0], rx_data};
                    w_cnt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state = S_BUS;
                        w_cnt   = 2'd0;
                        w_tmo   = '0;
                    end
                end
            end
            S_BUS: begin
                // Ack beats a coincident timeout terminal count
                if (wb_ack_i) begin
                    w_state    = S_RESP;
                    w_cnt      = 2'd0;
                    w_err      = 1'b0;
                    w_rdata    = wb_dat_i[23:0];
                    w_tx_valid = 1'b1;
                    w_tx_data  = r_op_we ? RSP_OK : wb_dat_i[31:24];
                end else if (r_tmo == TMO_LAST) begin
                    w_state    = S_RESP;
                    w_cnt      = 2'd0;
                    w_err      = 1'b1;
                    w_tx_valid = 1'b1;
                    w_tx_data  = RSP_ERR;
                end else begin
                    w_tmo = r_tmo + TMO_W'(1);
                end
            end
            S_RESP: begin
                if (r_tx_valid && tx_ready) begin
                    if (r_err || r_op_we || r_cnt == 2'd3) begin
                        w_state    = S_IDLE;
                        w_tx_valid = 1'b0;
                        w_cnt      = 2'd0;
                    end else begin
                        w_cnt     = r_cnt + 2'd1;
                        w_tx_data = r_rdata[23:16];
                        w_rdata   = {r_rdata[15:0], 8'h00};
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_cyc  = (w_state == S_BUS);
        w_we   = w_cyc & w_op_we;
        w_sel  = w_cyc ? 4'hF : 4'h0;
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op_we    <= 1'b0;
            r_cnt      <= 2'd0;
            r_tmo      <= '0;
            r_adr      <= 32'd0;
            r_dat      <= 32'd0;
            r_rdata    <= 24'd0;
            r_err      <= 1'b0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_op_we    <= w_op_we;
            r_cnt      <= w_cnt;
            r_tmo      <= w_tmo;
            r_adr      <= w_adr;
            r_dat      <= w_dat;
            r_rdata    <= w_rdata;
            r_err      <= w_err;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_cyc      <= w_cyc;
            r_we       <= w_we;
            r_sel      <= w_sel;
            r_busy     <= w_busy;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign busy     = r_busy;

endmodule
